// File: rtl/test_ram_pkg.sv
// Shared definitions for the test_ram SRAM model: default geometry and
// the controller state encoding used by the init sequencer.
package test_ram_pkg;

    // Default geometry: 64K words of 16 bits.
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // INIT: post-reset sweep writing each word with its own address.
    // READY: normal SRAM-style operation, terminal until the next reset.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_t;

endpackage : test_ram_pkg

// File: rtl/test_ram_init_seq.sv
// Post-reset initialisation sequencer for test_ram.
// Walks a pointer through every address, presenting address/data/strobe
// for the pattern mem[a] = a, then hands the memory write port over to
// the external SRAM interface once the last word has been written.
module test_ram_init_seq
    import test_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk50mhz,
    input  logic              rst_n,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              init_done
);

    ram_state_t        state_q;
    ram_state_t        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              sweep_last;

    // The edge that writes the final address is the one that leaves INIT.
    assign sweep_last = (ptr_q == {ADDR_W{1'b1}});

    // State and sweep pointer; reset restarts the sweep from address 0.
    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    // Next state plus the memory write port: the sweep owns it during INIT,
    // the external interface owns it once READY.
    always_comb begin
        state_d  = state_q;
        mem_we   = 1'b0;
        mem_addr = ext_addr;
        mem_data = ext_data;
        case (state_q)
            INIT: begin
                mem_we   = 1'b1;
                mem_addr = ptr_q;
                mem_data = DATA_W'(ptr_q);
                if (sweep_last) begin
                    state_d = READY;
                end
            end
            READY: begin
                mem_we   = ext_we;
                mem_addr = ext_addr;
                mem_data = ext_data;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // init_done is a decode of the registered state, so it drops the
    // moment reset asserts and rises on the edge that ends the sweep.
    assign init_done = (state_q == READY);

endmodule : test_ram_init_seq

// File: rtl/test_ram.sv
// SRAM-style test memory behind the VGA/memory-controller logic.
// Active-low WE/OE with a shared tri-state data bus; after reset every
// word is initialised to its own address before the bus becomes usable.
module test_ram
    import test_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk50mhz,
    input  logic              rst_n,
    input  logic              WE,
    input  logic              OE,
    input  logic [ADDR_W-1:0] ADDR,
    inout  logic [DATA_W-1:0] DATA,
    output logic              init_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ext_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              drive_en;
    logic [DATA_W-1:0] rd_data;

    // External write request; the sequencer ignores it until READY.
    // A write with OE also low still writes, and the bus stays released
    // so the external master's data is what gets stored.
    assign ext_we = ~WE;

    test_ram_init_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_init_seq (
        .clk50mhz  (clk50mhz),
        .rst_n     (rst_n),
        .ext_we    (ext_we),
        .ext_addr  (ADDR),
        .ext_data  (DATA),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .init_done (init_done)
    );

    // Storage array: contents are never reset, only rewritten by the sweep.
    // While rst_n is low the sequencer is held in INIT at address 0, so the
    // only write that can happen is the harmless mem[0] <= 0 pattern word;
    // an external write presented during reset is dropped.
    always_ff @(posedge clk50mhz) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    // Asynchronous read path, so a new ADDR or a just-written word is
    // visible on the bus without waiting for a clock edge.
    assign rd_data = mem[ADDR];

    // Drive the bus only for a genuine read: initialised, OE low, WE high.
    assign drive_en = init_done & ~OE & WE;

    assign DATA = drive_en ? rd_data : {DATA_W{1'bz}};

endmodule : test_ram

// File: tb/tb_test_ram.sv
// Scoreboard testbench for test_ram with a 4-bit address space.
// Stimulus pushes expected bus/status observations into a queue; a
// monitor on the falling clock edge pops and compares them.
module tb_test_ram;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    typedef enum {K_DATA, K_HIZ, K_DONE} kind_t;

    typedef struct {
        kind_t             kind;
        logic [DATA_W-1:0] val;
        string             name;
    } exp_t;

    logic              clk50mhz;
    logic              rst_n;
    logic              we;
    logic              oe;
    logic [ADDR_W-1:0] addr;
    wire  [DATA_W-1:0] data_bus;
    logic              init_done;

    logic              tb_drive_en;
    logic [DATA_W-1:0] tb_drive_val;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    assign data_bus = tb_drive_en ? tb_drive_val : {DATA_W{1'bz}};

    test_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk50mhz  (clk50mhz),
        .rst_n     (rst_n),
        .WE        (we),
        .OE        (oe),
        .ADDR      (addr),
        .DATA      (data_bus),
        .init_done (init_done)
    );

    // 50 MHz clock.
    initial begin
        clk50mhz = 1'b0;
        forever #10 clk50mhz = ~clk50mhz;
    end

    // Monitor: on each falling edge, compare every pending expectation.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk50mhz);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                ok = 1'b0;
                case (e.kind)
                    K_DATA: begin
                        ok = (dut.drive_en === 1'b1) && (data_bus === e.val);
                        if (!ok)
                            $display("[TB] FAIL %s: got drive=%b data=%h, want drive=1 data=%h",
                                     e.name, dut.drive_en, data_bus, e.val);
                    end
                    K_HIZ: begin
                        ok = (dut.drive_en === 1'b0);
                        if (!ok)
                            $display("[TB] FAIL %s: got drive=%b, want drive=0 (released bus)",
                                     e.name, dut.drive_en);
                    end
                    K_DONE: begin
                        ok = (init_done === e.val[0]);
                        if (!ok)
                            $display("[TB] FAIL %s: got init_done=%b, want %b",
                                     e.name, init_done, e.val[0]);
                    end
                    default: ok = 1'b0;
                endcase
                if (!ok) errors++;
            end
        end
    end

    task automatic applyStimulus(input logic we_v, input logic oe_v,
                                 input logic [ADDR_W-1:0] addr_v,
                                 input logic drv, input logic [DATA_W-1:0] val);
        we           = we_v;
        oe           = oe_v;
        addr         = addr_v;
        tb_drive_en  = drv;
        tb_drive_val = val;
    endtask

    task automatic pushExpect(input kind_t kind, input logic [DATA_W-1:0] val,
                              input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic checkOutput();
        for (int n = 0; n < 3; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk50mhz);
            #1;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk50mhz);
        #1;
    endtask

    task automatic readExpect(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v,
                              input string name);
        applyStimulus(1'b1, 1'b0, a, 1'b0, '0);
        pushExpect(K_DATA, v, name);
        checkOutput();
    endtask

    task automatic writeWord(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        applyStimulus(1'b0, 1'b1, a, 1'b1, v);
        tick();
    endtask

    // Directed stimulus sequence.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'd5, 1'b0, '0);
        repeat (3) @(posedge clk50mhz);
        #1;

        // Reset state: not initialised, bus released even with OE low.
        pushExpect(K_DONE, 16'd0, "reset_init_done");
        pushExpect(K_HIZ, 16'd0, "reset_bus_z");
        checkOutput();
        rst_n = 1'b1;

        // Sweep: init_done must rise on exactly the 16th edge; reads are
        // refused and writes ignored while the sweep runs.
        for (int i = 1; i <= 16; i++) begin
            tick();
            pushExpect(K_DONE, (i == 16) ? 16'd1 : 16'd0, $sformatf("sweep_done_e%0d", i));
            if (i < 16) pushExpect(K_HIZ, 16'd0, $sformatf("sweep_bus_z_e%0d", i));
            checkOutput();
            if (i == 8) applyStimulus(1'b0, 1'b1, 4'd9, 1'b1, 16'hDEAD);
        end
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, '0);

        readExpect(4'd5, 16'h0005, "init_read_a5");
        readExpect(4'd9, 16'h0009, "init_write_ignored_a9");
        readExpect(4'd15, 16'h000F, "init_read_last_a15");

        // Write then read back, plus a neighbouring untouched word.
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b1, 16'hBEEF);
        pushExpect(K_HIZ, 16'd0, "write_bus_released");
        checkOutput();
        tick();
        readExpect(4'd3, 16'hBEEF, "readback_a3");
        readExpect(4'd4, 16'h0004, "neighbour_a4");

        // Read-modify-write loop on address 0.
        for (int k = 0; k < 4; k++) begin
            readExpect(4'd0, DATA_W'(k), $sformatf("rmw_read_%0d", k));
            writeWord(4'd0, DATA_W'(k + 1));
        end
        readExpect(4'd0, 16'h0004, "rmw_final");

        // WE and OE both low: write wins, bus not driven by the memory.
        applyStimulus(1'b0, 1'b0, 4'd6, 1'b1, 16'h1234);
        pushExpect(K_HIZ, 16'd0, "we_oe_low_no_drive");
        checkOutput();
        tick();
        readExpect(4'd6, 16'h1234, "we_oe_low_wrote");

        // Both high: idle, bus released, memory unchanged.
        applyStimulus(1'b1, 1'b1, 4'd6, 1'b1, 16'h5555);
        pushExpect(K_HIZ, 16'd0, "idle_no_drive");
        checkOutput();
        tick();
        tick();
        readExpect(4'd6, 16'h1234, "idle_unchanged");

        // Mid-operation reset: a written word is restored by the new sweep,
        // and a write presented across a reset edge is dropped.
        writeWord(4'd2, 16'hAAAA);
        readExpect(4'd2, 16'hAAAA, "pre_reset_a2");
        pushExpect(K_DONE, 16'd1, "pre_reset_done");
        checkOutput();
        rst_n = 1'b0;
        #1;
        pushExpect(K_DONE, 16'd0, "async_reset_done");
        pushExpect(K_HIZ, 16'd0, "async_reset_bus_z");
        checkOutput();
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b1, 16'h7777);
        tick();
        pushExpect(K_DONE, 16'd0, "reset_held_done");
        checkOutput();
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            pushExpect(K_DONE, (i == 16) ? 16'd1 : 16'd0, $sformatf("resweep_done_e%0d", i));
            checkOutput();
        end
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, '0);
        readExpect(4'd2, 16'h0002, "post_reset_a2");
        readExpect(4'd3, 16'h0003, "post_reset_a3");
        readExpect(4'd0, 16'h0000, "post_reset_a0");
        readExpect(4'd15, 16'h000F, "post_reset_a15");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion, want finish before limit");
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_test_ram

// File: doc/test_ram.md
Name: test_ram

Overview:
- 16-bit-wide, SRAM-style test memory with active-low write and output enables and a shared tri-state data bus.
- Serves as the frame/scratch memory model behind the VGA/memory-controller logic, clocked from the 50 MHz domain.
- After reset it self-initialises every word to its own address, so reads return known values before any write.

Parameters:
- ADDR_W, 16, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 16, word width.

Ports:
- clk50mhz  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- WE  input  1  write enable, active low.
- OE  input  1  output enable, active low.
- ADDR  input  ADDR_W  word address, unsigned, bit ADDR_W-1 is MSB.
- DATA  inout  DATA_W  bidirectional data bus; driven by test_ram only during a valid read, else high-Z.
- init_done  output  1  high once the post-reset initialisation sweep has completed.

Behaviour:
- One clock (clk50mhz); reset asynchronous, active-low (rst_n).
- Storage: DEPTH x DATA_W array, no reset of contents, only the sweep below.
- States: INIT, READY.
  - rst_n=0 -> state INIT, sweep pointer=0, init_done=0 immediately (async).
  - INIT: each rising edge writes mem[ptr] <= ptr (zero-extended/truncated to DATA_W), ptr++.
  - The edge writing address DEPTH-1 moves to READY and sets init_done=1 (registered). Sweep takes exactly DEPTH cycles after rst_n release.
  - READY: terminal until next reset.
- While in INIT:
  - WE/OE are ignored.
  - DATA is high-Z.
- Write (READY): on rising edge with WE=0, mem[ADDR] <= DATA. ADDR/DATA are sampled at that edge.
- Read (READY): DATA = mem[ADDR] combinationally whenever OE=0 and WE=1; zero-cycle latency from ADDR change.
- WE=0 and OE=0 together: write wins; test_ram does not drive DATA (no bus contention).
- WE=1 and OE=1: idle, DATA high-Z, no state change.
- Read-after-write to the same address: value visible on DATA immediately after the writing edge.
- Address wrap: ADDR is full-range; no out-of-range case exists.
- Reset mid-operation: any in-progress sweep restarts from 0; prior writes are overwritten by the pattern.
- Reset asserted during a write edge: the write is discarded.
- Reset values: init_done=0, DATA=Z, state INIT, ptr=0.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults and the state encoding (INIT, READY).
- Optional sub-module test_ram_init_seq: sweep counter plus init_done, outputting write address/data/strobe muxed with the external write port.
- Everything else stays in test_ram.

Test Plan:
- Init sweep (ADDR_W=4 for speed): release rst_n, count edges -> init_done rises on the 16th edge; DATA is Z before it rises; then WE=1, OE=0, ADDR=5 -> DATA=16'h0005.
- Write/read: WE=0, OE=1, ADDR=3, drive DATA=16'hBEEF, one edge; release bus, WE=1, OE=0 -> DATA=16'hBEEF; ADDR=4 -> DATA=16'h0004.
- Read-modify-write loop (ADDR=0): read 0x0000, write back +1 four times -> final read 0x0004.
- Enable combinations: WE=0, OE=0 -> DATA not driven by DUT and write occurs; WE=1, OE=1 -> DATA=Z and memory unchanged.
- Mid-operation reset: write 0xAAAA to ADDR 2, pulse rst_n low between edges -> init_done=0 immediately; after sweep, ADDR 2 reads 0x0002.
- Writes attempted during INIT with WE=0 -> ignored; after init_done, the targeted address holds its pattern value.
